// File: rtl/mdu_if.sv
// mdu_if: EX-stage handshake between the pipeline and the multiply/divide unit.
interface mdu_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master(output start, op, a, b, md_use, input busy, stall, hi, lo);
  modport slave(input start, op, a, b, md_use, output busy, stall, hi, lo);
endinterface

// File: rtl/mdu_unit.sv
// mdu_unit: MIPS multi-cycle MULT/DIV unit owning HI/LO; defining MDU_MADD_EN adds MADD/MADDU.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  mdu_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_d;
  logic [4:0] cnt;
  logic [63:0] res, res_d, smul, umul;
  logic [31:0] hi_r, lo_r, aa, bb, q, r, sq, sr;
  logic wr, wr_d, is_mul, is_div, sdiv, go;
  always_comb begin
    smul = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
    umul = {32'b0, bus.a} * {32'b0, bus.b};
    sdiv = bus.op == 4'd3;
    // signed divide works on magnitudes, then restores signs (remainder follows dividend)
    aa = (sdiv && bus.a[31]) ? -bus.a : bus.a;
    bb = (sdiv && bus.b[31]) ? -bus.b : bus.b;
    q = (bb == 32'd0) ? 32'd0 : aa / bb;
    r = (bb == 32'd0) ? 32'd0 : aa % bb;
    sq = (sdiv && (bus.a[31] ^ bus.b[31])) ? -q : q;
    sr = (sdiv && bus.a[31]) ? -r : r;
    is_div = bus.op == 4'd3 || bus.op == 4'd4;
`ifdef MDU_MADD_EN
    is_mul = bus.op == 4'd1 || bus.op == 4'd2 || bus.op == 4'd7 || bus.op == 4'd8;
    res_d = bus.op == 4'd1 ? smul : bus.op == 4'd2 ? umul :
            bus.op == 4'd7 ? {hi_r, lo_r} + smul : bus.op == 4'd8 ? {hi_r, lo_r} + umul : {sr, sq};
`else
    is_mul = bus.op == 4'd1 || bus.op == 4'd2;
    res_d = bus.op == 4'd1 ? smul : bus.op == 4'd2 ? umul : {sr, sq};
`endif
    wr_d = !is_div || bb != 32'd0;
    go = state == IDLE && bus.start && (is_mul || is_div);
    state_d = go ? RUN : (state == RUN && cnt == 5'd1) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= 5'd0;
      res <= 64'd0;
      wr <= 1'b0;
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else begin
      state <= state_d;
      if (go) begin
        res <= res_d;
        wr <= wr_d;
        cnt <= is_mul ? 5'(MULT_CYCLES) : 5'(DIV_CYCLES);
      end else if (state == RUN) begin
        cnt <= cnt - 5'd1;
        if (cnt == 5'd1 && wr) {hi_r, lo_r} <= res;
      end else begin
        if (bus.op == 4'd5) hi_r <= bus.a;
        if (bus.op == 4'd6) lo_r <= bus.a;
      end
    end
  end
  assign bus.busy = state == RUN;
  assign bus.stall = bus.md_use && (bus.start || state == RUN);
  assign bus.hi = hi_r;
  assign bus.lo = lo_r;
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: vector table plus hand sequences for stall, busy-time hazards and reset abort.
module tb_mdu_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  mdu_if bus();
  mdu_unit dut(.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    int          cyc;
    string       name;
  } vec_t;
  vec_t vecs[11];
  logic [63:0] sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // called at a negedge; operands are scrambled right after accept to prove they were latched
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] res, input int cyc, input string name);
    int n;
    logic [63:0] e;
    n = 0;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    sb.push_back(res);
    @(negedge clk);
    bus.start = 1'b0; bus.op = 4'd0; bus.a = 32'hA5A5A5A5; bus.b = 32'h5A5A5A5A;
    while (bus.busy && n < 64) begin
      n++;
      @(negedge clk);
    end
    chk({name, " busy cycles"}, 64'(n), 64'(cyc));
    e = sb.pop_front();
    chk({name, " hi:lo"}, {bus.hi, bus.lo}, e);
  endtask

  initial begin
    int n;
    vecs[0]  = '{4'd1, 32'hFFFFFFFE, 32'd3,        64'hFFFFFFFF_FFFFFFFA, 5,  "mult -2*3"};
    vecs[1]  = '{4'd2, 32'hFFFFFFFE, 32'd3,        64'h00000002_FFFFFFFA, 5,  "multu"};
    vecs[2]  = '{4'd9, 32'd1,        32'd1,        64'h00000002_FFFFFFFA, 0,  "op9 noop"};
    vecs[3]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 10, "div -7/2"};
    vecs[4]  = '{4'd1, 32'd7,        32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 5,  "mult 7*-3"};
    vecs[5]  = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 5,  "multu max"};
    vecs[6]  = '{4'd3, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 10, "div 7/-2"};
    vecs[7]  = '{4'd4, 32'd100,      32'd7,        64'h00000002_0000000E, 10, "divu 100/7"};
    vecs[8]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 10, "div min/-1"};
    vecs[9]  = '{4'd4, 32'd7,        32'd0,        64'h00000000_80000000, 10, "divu by 0"};
    vecs[10] = '{4'd0, 32'd5,        32'd6,        64'h00000000_80000000, 0,  "op0 noop"};
    bus.start = 1'b0; bus.op = 4'd0; bus.a = 32'd0; bus.b = 32'd0; bus.md_use = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset hi:lo", {bus.hi, bus.lo}, 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    reset = 1'b1;
    bus.op = 4'd5; bus.a = 32'h12345678;
    @(negedge clk);
    chk("mthi busy", 64'(bus.busy), 64'd0);
    bus.op = 4'd6; bus.a = 32'h9ABCDEF0;
    @(negedge clk);
    chk("mtlo busy", 64'(bus.busy), 64'd0);
    bus.op = 4'd0;
    chk("mthi/mtlo hi:lo", {bus.hi, bus.lo}, 64'h12345678_9ABCDEF0);
    // stall window, MTLO and a second start while busy
    bus.md_use = 1'b1;
    #1 chk("stall idle", 64'(bus.stall), 64'd0);
    bus.start = 1'b1; bus.op = 4'd1; bus.a = 32'd3; bus.b = 32'd4;
    #1 chk("stall accept", 64'(bus.stall), 64'd1);
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 64) begin
      n++;
      chk("stall busy", 64'(bus.stall), 64'd1);
      if (n == 1) begin
        bus.op = 4'd6; bus.a = 32'hDEADBEEF;
      end else if (n == 2) begin
        chk("mtlo while busy", 64'(bus.lo), 64'h9ABCDEF0);
        bus.start = 1'b1; bus.op = 4'd3; bus.a = 32'd1; bus.b = 32'd1;
      end else begin
        bus.start = 1'b0; bus.op = 4'd0;
      end
      @(negedge clk);
    end
    chk("busy restart", 64'(n), 64'd5);
    chk("stall after", 64'(bus.stall), 64'd0);
    chk("mult 3*4 hi:lo", {bus.hi, bus.lo}, 64'h00000000_0000000C);
    bus.md_use = 1'b0;
    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].cyc, vecs[i].name);
    // reset on busy cycle 4 aborts the divide
    bus.start = 1'b1; bus.op = 4'd4; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 4'd0;
    repeat (3) @(negedge clk);
    chk("abort busy before", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort hi:lo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort late busy", 64'(bus.busy), 64'd0);
    chk("abort late hi:lo", {bus.hi, bus.lo}, 64'd0);
    bus.op = 4'd5; bus.a = 32'd0;
    @(negedge clk);
    bus.op = 4'd6; bus.a = 32'hFFFFFFFF;
    @(negedge clk);
    bus.op = 4'd0;
`ifdef MDU_MADD_EN
    run_op(4'd8, 32'd1, 32'd1, 64'h00000001_00000000, 5, "maddu");
    run_op(4'd7, 32'hFFFFFFFF, 32'd2, 64'h00000000_FFFFFFFE, 5, "madd");
`else
    run_op(4'd7, 32'd3, 32'd4, 64'h00000000_FFFFFFFF, 0, "op7 noop");
    run_op(4'd8, 32'd3, 32'd4, 64'h00000000_FFFFFFFF, 0, "op8 noop");
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
